// File: rtl/password_lock_pkg.sv
// password_lock_pkg: shared types and helpers for param_password_lock.
//   lock_state_t : main FSM state encoding (also exported on dbgState)
//   idxWidth     : width of a digit-position index for a password of N digits
package password_lock_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ENTER    = 3'd1,
    S_ERROR    = 3'd2,
    S_UNLOCKED = 3'd3,
    S_SET      = 3'd4,
    S_LOCKED   = 3'd5
  } lock_state_t;

  function automatic int unsigned idxWidth(input int unsigned passLen);
    return (passLen <= 2) ? 1 : $clog2(passLen);
  endfunction

endpackage

// File: rtl/password_store.sv
// password_store: PASS_LEN x DIGIT_W password register array.
//   CLK, RST   : clock, asynchronous active-high reset (store clears to all zeros)
//   commit     : load the whole of commitData in one cycle
//   commitData : new password, digit 0 in the most significant DIGIT_W bits
//   rdIdx      : digit position to read
//   rdDigit    : asynchronous read of the stored digit at rdIdx
module password_store
  import password_lock_pkg::*;
#(
  parameter int unsigned DIGIT_W  = 4,
  parameter int unsigned PASS_LEN = 4
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                commit,
  input  logic [PASS_LEN*DIGIT_W-1:0]         commitData,
  input  logic [idxWidth(PASS_LEN)-1:0]       rdIdx,
  output logic [DIGIT_W-1:0]                  rdDigit
);

  localparam int unsigned IdxW = idxWidth(PASS_LEN);

  logic [DIGIT_W-1:0] storeQ [PASS_LEN];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < PASS_LEN; i++) storeQ[i] <= '0;
    end else if (commit) begin
      for (int i = 0; i < PASS_LEN; i++) begin
        storeQ[i] <= commitData[(PASS_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
  end

  // Mux form keeps the read in range for non-power-of-two lengths.
  always_comb begin
    rdDigit = '0;
    for (int i = 0; i < PASS_LEN; i++) begin
      if (rdIdx == IdxW'(i)) rdDigit = storeQ[i];
    end
  end

endmodule

// File: rtl/param_password_lock.sv
// param_password_lock: parametrised serial password lock with lockdown and admin recovery.
//   CLK, RST      : clock, asynchronous active-high reset
//   setMode       : request password programming (honoured only while unlocked)
//   digitValid    : digit strobe, digit accepted this cycle
//   digit         : entered digit
//   unlockLight   : correct password entered
//   errorLight    : last entry failed
//   warningLight  : lockdown active
//   dbgState      : current main state encoding
//   dbgTries      : consecutive failure count
// Optional feature: define PASSWORD_LOCK_TIMEOUT_EN to enable the idle timeout.
module param_password_lock
  import password_lock_pkg::*;
#(
  parameter int unsigned                     DIGIT_W     = 4,
  parameter int unsigned                     PASS_LEN    = 4,
  parameter int unsigned                     MAX_TRIES   = 3,
  parameter logic [PASS_LEN*DIGIT_W-1:0]     ADMIN_CODE  = 16'h0129,
  parameter int unsigned                     TIMEOUT_CYC = 1000
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               setMode,
  input  logic                               digitValid,
  input  logic [DIGIT_W-1:0]                 digit,
  output logic                               unlockLight,
  output logic                               errorLight,
  output logic                               warningLight,
  output logic [2:0]                         dbgState,
  output logic [$clog2(MAX_TRIES+1)-1:0]     dbgTries
);

  localparam int unsigned IdxW   = idxWidth(PASS_LEN);
  localparam int unsigned TriesW = $clog2(MAX_TRIES + 1);
  localparam int unsigned PassW  = PASS_LEN * DIGIT_W;
  localparam logic [IdxW-1:0]    LastIdx    = IdxW'(PASS_LEN - 1);
  localparam logic [TriesW-1:0]  MaxTries   = TriesW'(MAX_TRIES);
  localparam logic [DIGIT_W-1:0] AdminFirst = ADMIN_CODE[PassW-1 -: DIGIT_W];

  lock_state_t         stateQ;
  logic [IdxW-1:0]     idxQ;
  logic                mismatchQ;
  logic [TriesW-1:0]   triesQ;
  logic [PassW-1:0]    shadowQ;

  logic [DIGIT_W-1:0]  rdDigit;
  logic [DIGIT_W-1:0]  adminDigit;
  logic [PassW-1:0]    commitData;
  logic [TriesW-1:0]   triesInc;
  logic                lastDigit;
  logic                commit;
  logic                timeoutHit;

  always_comb begin
    lastDigit  = (idxQ == LastIdx);
    commitData = {shadowQ[PassW-DIGIT_W-1:0], digit};
    commit     = (stateQ == S_SET) && digitValid && setMode && lastDigit;
    triesInc   = (triesQ == MaxTries) ? triesQ : triesQ + TriesW'(1);
    adminDigit = '0;
    for (int i = 0; i < PASS_LEN; i++) begin
      if (idxQ == IdxW'(i)) adminDigit = ADMIN_CODE[(PASS_LEN-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  password_store #(
    .DIGIT_W  (DIGIT_W),
    .PASS_LEN (PASS_LEN)
  ) uStore (
    .CLK        (CLK),
    .RST        (RST),
    .commit     (commit),
    .commitData (commitData),
    .rdIdx      (idxQ),
    .rdDigit    (rdDigit)
  );

`ifdef PASSWORD_LOCK_TIMEOUT_EN
  localparam int unsigned        IdleW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IdleW-1:0]   IdleMax = IdleW'(TIMEOUT_CYC);

  logic [IdleW-1:0] idleQ;
  lock_state_t      prevStateQ;

  // Restarts on any strobe or state change; held at zero in lockdown.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idleQ      <= '0;
      prevStateQ <= S_IDLE;
    end else begin
      prevStateQ <= stateQ;
      if (digitValid || (stateQ != prevStateQ) || (stateQ == S_LOCKED)) begin
        idleQ <= '0;
      end else if (idleQ != IdleMax) begin
        idleQ <= idleQ + IdleW'(1);
      end
    end
  end

  assign timeoutHit = (idleQ == IdleMax) &&
                      ((stateQ == S_ENTER) || (stateQ == S_SET) || (stateQ == S_UNLOCKED));
`else
  assign timeoutHit = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stateQ       <= S_IDLE;
      idxQ         <= '0;
      mismatchQ    <= 1'b0;
      triesQ       <= '0;
      shadowQ      <= '0;
      unlockLight  <= 1'b0;
      errorLight   <= 1'b0;
      warningLight <= 1'b0;
    end else begin
      unique case (stateQ)
        S_IDLE, S_ERROR, S_UNLOCKED: begin
          if ((stateQ == S_UNLOCKED) && setMode) begin
            stateQ <= S_SET;
            idxQ   <= '0;
          end else if (digitValid) begin
            mismatchQ   <= (digit != rdDigit);
            idxQ        <= IdxW'(1);
            stateQ      <= S_ENTER;
            unlockLight <= 1'b0;
            errorLight  <= 1'b0;
          end else if (timeoutHit) begin
            stateQ      <= S_IDLE;
            unlockLight <= 1'b0;
          end
        end
        S_ENTER: begin
          if (digitValid) begin
            if (lastDigit) begin
              // Verdict only after the full entry, so the error position stays hidden.
              idxQ      <= '0;
              mismatchQ <= 1'b0;
              if (!(mismatchQ || (digit != rdDigit))) begin
                stateQ      <= S_UNLOCKED;
                unlockLight <= 1'b1;
                triesQ      <= '0;
              end else begin
                triesQ <= triesInc;
                if (triesInc == MaxTries) begin
                  stateQ       <= S_LOCKED;
                  warningLight <= 1'b1;
                end else begin
                  stateQ     <= S_ERROR;
                  errorLight <= 1'b1;
                end
              end
            end else begin
              mismatchQ <= mismatchQ | (digit != rdDigit);
              idxQ      <= idxQ + IdxW'(1);
            end
          end else if (timeoutHit) begin
            stateQ    <= S_IDLE;
            idxQ      <= '0;
            mismatchQ <= 1'b0;
          end
        end
        S_SET: begin
          if (!setMode || (!digitValid && timeoutHit)) begin
            // Abort: shadow is simply never committed.
            stateQ      <= S_IDLE;
            idxQ        <= '0;
            unlockLight <= 1'b0;
          end else if (digitValid) begin
            shadowQ <= commitData;
            if (lastDigit) begin
              stateQ      <= S_IDLE;
              idxQ        <= '0;
              unlockLight <= 1'b0;
            end else begin
              idxQ <= idxQ + IdxW'(1);
            end
          end
        end
        S_LOCKED: begin
          if (digitValid) begin
            if (digit == adminDigit) begin
              if (lastDigit) begin
                stateQ       <= S_IDLE;
                idxQ         <= '0;
                triesQ       <= '0;
                warningLight <= 1'b0;
              end else begin
                idxQ <= idxQ + IdxW'(1);
              end
            end else begin
              // Restart: the breaking digit may itself begin a new admin attempt.
              idxQ <= (digit == AdminFirst) ? IdxW'(1) : '0;
            end
          end
        end
        default: stateQ <= S_IDLE;
      endcase
    end
  end

  assign dbgState = stateQ;
  assign dbgTries = triesQ;

endmodule

// File: tb/tb_param_password_lock.sv
// Bench for param_password_lock: directed scenarios plus randomized traffic, with a
// queue-based scoreboard. Expected light/try values come from an entry-level model:
// whole entries are compared to the stored password, and lockdown ends when the last
// PASS_LEN digits seen since lockdown spell the admin code (the default code 0,1,2,9
// has no self-overlap, so that equals the digit-restart rule).
module tb_param_password_lock;
  import password_lock_pkg::*;

  localparam int unsigned DW = 4;
  localparam int unsigned PL = 4;
  localparam int unsigned MT = 3;
  localparam logic [15:0] ADMIN = 16'h0129;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       setMode = 1'b0;
  logic       digitValid = 1'b0;
  logic [3:0] digit = '0;
  logic       unlockLight, errorLight, warningLight;
  logic [2:0] dbgState;
  logic [1:0] dbgTries;

  param_password_lock #(
    .DIGIT_W     (DW),
    .PASS_LEN    (PL),
    .MAX_TRIES   (MT),
    .ADMIN_CODE  (ADMIN),
    .TIMEOUT_CYC (1000)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .setMode      (setMode),
    .digitValid   (digitValid),
    .digit        (digit),
    .unlockLight  (unlockLight),
    .errorLight   (errorLight),
    .warningLight (warningLight),
    .dbgState     (dbgState),
    .dbgTries     (dbgTries)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int unsigned cycle;
    bit          chkState;
    logic        u;
    logic        e;
    logic        w;
    logic [1:0]  t;
    string       tag;
  } exp_t;

  exp_t expQ[$];
  bit   stimDone = 1'b0;

  // ---------------- reference model ----------------
  int pw[PL];
  int adminDig[PL];
  int tries;
  bit mLocked, mUnlock, mError;
  int entryBuf[$];
  int adminHist[$];

  function automatic void pushExp(input int unsigned at, input string tag, input bit chk);
    exp_t e;
    e.cycle    = at;
    e.chkState = chk;
    e.u        = mUnlock;
    e.e        = mError;
    e.w        = mLocked;
    e.t        = 2'(tries);
    e.tag      = tag;
    expQ.push_back(e);
  endfunction

  function automatic void modelDigit(input int d);
    bit match;
    if (mLocked) begin
      adminHist.push_back(d);
      if (adminHist.size() > PL) void'(adminHist.pop_front());
      if (adminHist.size() == PL) begin
        match = 1'b1;
        for (int i = 0; i < PL; i++) if (adminHist[i] != adminDig[i]) match = 1'b0;
        if (match) begin
          mLocked = 1'b0;
          tries   = 0;
          adminHist.delete();
        end
      end
    end else begin
      if (entryBuf.size() == 0) begin
        mUnlock = 1'b0;
        mError  = 1'b0;
      end
      entryBuf.push_back(d);
      if (entryBuf.size() == PL) begin
        match = 1'b1;
        for (int i = 0; i < PL; i++) if (entryBuf[i] != pw[i]) match = 1'b0;
        entryBuf.delete();
        if (match) begin
          mUnlock = 1'b1;
          tries   = 0;
        end else begin
          if (tries < MT) tries++;
          if (tries >= MT) mLocked = 1'b1;
          else mError = 1'b1;
        end
      end
    end
  endfunction

  // ---------------- stimulus ----------------
  // All tasks start and end just after a rising edge.
  task automatic strobe(input int d, input string tag);
    digitValid = 1'b1;
    digit      = 4'(d);
    modelDigit(d);
    pushExp(cyc + 1, tag, 1'b0);
    @(posedge CLK); #1;
    digitValid = 1'b0;
  endtask

  task automatic entry(input int d[PL], input bit gaps, input string tag);
    for (int i = 0; i < PL; i++) begin
      strobe(d[i], tag);
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
    end
  endtask

  // Caller guarantees the model is unlocked. stopAfter < PL aborts by dropping setMode.
  task automatic setPassword(input int nd[PL], input int stopAfter, input string tag);
    setMode    = 1'b1;
    digitValid = 1'b0;
    @(posedge CLK); #1;
    for (int i = 0; i < stopAfter; i++) begin
      digitValid = 1'b1;
      digit      = 4'(nd[i]);
      if (i == PL - 1) begin
        for (int k = 0; k < PL; k++) pw[k] = nd[k];
        mUnlock = 1'b0;
        pushExp(cyc + 1, tag, 1'b0);
      end
      @(posedge CLK); #1;
    end
    digitValid = 1'b0;
    if (stopAfter < PL) begin
      setMode = 1'b0;
      mUnlock = 1'b0;
      pushExp(cyc + 1, tag, 1'b0);
      @(posedge CLK); #1;
    end
    setMode = 1'b0;
  endtask

  function automatic int randAdminish();
    int pick;
    pick = int'($urandom_range(0, PL - 1));
    return adminDig[pick];
  endfunction

  initial begin
    int d[PL];
    int r;
    logic [15:0] adminCode;
    adminCode = ADMIN;
    for (int i = 0; i < PL; i++) begin
      pw[i]       = 0;
      adminDig[i] = int'(adminCode[(PL-1-i)*DW +: DW]);
    end
    tries = 0; mLocked = 0; mUnlock = 0; mError = 0;

    #2 RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    pushExp(cyc, "reset", 1'b1);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    entry('{0, 0, 0, 0}, 1'b0, "default_unlock");
    entry('{1, 0, 0, 0}, 1'b0, "wrong_first");
    entry('{2, 2, 2, 2}, 1'b1, "wrong_2");
    entry('{3, 3, 3, 3}, 1'b0, "wrong_3_lock");
    entry('{0, 0, 0, 0}, 1'b0, "locked_ignore");
    entry('{0, 1, 2, 9}, 1'b0, "admin_clear");
    entry('{0, 0, 0, 0}, 1'b0, "unlock_again");
    setPassword('{5, 6, 7, 8}, PL, "set_commit");
    entry('{0, 0, 0, 0}, 1'b0, "old_pw_fails");
    entry('{5, 6, 7, 8}, 1'b0, "new_pw_unlocks");
    setPassword('{1, 2, 3, 4}, 2, "set_abort");
    entry('{5, 6, 7, 8}, 1'b0, "kept_pw_unlocks");
    setPassword('{9, 9, 1, 1}, PL, "set_commit2");
    entry('{9, 9, 1, 1}, 1'b0, "next_cycle_new_pw");
    for (int k = 0; k < 3; k++) entry('{1, 1, 1, 1}, 1'b0, "relock");
    foreach (d[i]) d[i] = 0;
    strobe(0, "admin_restart"); strobe(1, "admin_restart");
    strobe(0, "admin_restart"); strobe(1, "admin_restart");
    strobe(2, "admin_restart"); strobe(9, "admin_restart");
    entry('{9, 9, 1, 1}, 1'b0, "after_restart");

    for (int it = 0; it < 150; it++) begin
      r = int'($urandom_range(0, 9));
      if (mLocked) begin
        if (r < 4) d = adminDig;
        else foreach (d[i]) d[i] = randAdminish();
        entry(d, r[0], "rand_locked");
      end else if (mUnlock && r < 3) begin
        foreach (d[i]) d[i] = int'($urandom_range(0, 3));
        setPassword(d, int'($urandom_range(1, PL)), "rand_set");
      end else if (r < 6) begin
        entry(pw, r[0], "rand_correct");
      end else begin
        foreach (d[i]) d[i] = int'($urandom_range(0, 3));
        entry(d, r[0], "rand_entry");
      end
    end
    stimDone = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  int checks = 0;
  int fails  = 0;
  int drain  = 0;

  always @(negedge CLK) begin
    exp_t e;
    while (expQ.size() > 0 && expQ[0].cycle <= cyc) begin
      e = expQ.pop_front();
      checks++;
      if (e.cycle != cyc ||
          {unlockLight, errorLight, warningLight, dbgTries} != {e.u, e.e, e.w, e.t} ||
          (e.chkState && dbgState != 3'(S_IDLE))) begin
        fails++;
        $display("FAIL %s cyc=%0d: got u/e/w/tries/state=%b/%b/%b/%0d/%0d expected %b/%b/%b/%0d (cyc %0d)",
                 e.tag, cyc, unlockLight, errorLight, warningLight, dbgTries, dbgState,
                 e.u, e.e, e.w, e.t, e.cycle);
      end
    end
    if (stimDone) begin
      if (expQ.size() == 0 || drain >= 20) begin
        if (expQ.size() != 0) begin
          fails++;
          $display("FAIL drain: got %0d pending expectations, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
      end
      drain++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
